// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - register rename stage: RAT lookup, free-list allocation and retire-side reclaim
module rename_stage #(
    parameter  int PHYS_REGS = 64,
    localparam int PREG_W    = $clog2(PHYS_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    input  logic [31:0]       imm,
    input  logic [2:0]        alu_op,
    input  logic              alu_src,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PREG_W-1:0] ps1,
    output logic [PREG_W-1:0] ps2,
    output logic [PREG_W-1:0] pd,
    output logic [PREG_W-1:0] old_pd,
    output logic [31:0]       out_imm,
    output logic [2:0]        out_alu_op,
    output logic              out_alu_src,
    output logic              out_mem_to_reg,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    input  logic              retire_valid,
    input  logic [PREG_W-1:0] retire_pd,
    output logic              fl_overflow
);

    localparam int FL_DEPTH = PHYS_REGS - 32;
    localparam int HW       = $clog2(FL_DEPTH);
    localparam int CW       = $clog2(FL_DEPTH + 1);
    localparam logic [CW-1:0] FL_FULL = CW'(FL_DEPTH);

    logic [31:0][PREG_W-1:0]       rat_q, rat_d;
    logic [FL_DEPTH-1:0][PREG_W-1:0] free_q, free_d;
    logic [HW-1:0]                 head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]                 count_q, count_d;
    logic                          out_valid_q, out_valid_d;
    logic [PREG_W-1:0]             ps1_q, ps1_d, ps2_q, ps2_d, pd_q, pd_d, old_pd_q, old_pd_d;
    logic [31:0]                   imm_q, imm_d;
    logic [2:0]                    alu_op_q, alu_op_d;
    logic [4:0]                    ctrl_q, ctrl_d;
    logic                          ovf_q, ovf_d;

    logic accept, alloc, push_req, push;

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [HW-1:0] wrap_inc(input logic [HW-1:0] p);
        return (p == HW'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_ready = (!out_valid_q || out_ready) && (count_q != '0);
        accept   = in_valid && in_ready;
        alloc    = accept && reg_write && (rd != 5'd0);
        push_req = retire_valid && (retire_pd != '0);
        push     = push_req && (count_q != FL_FULL);

        rat_d       = rat_q;
        free_d      = free_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        ps1_d       = ps1_q;
        ps2_d       = ps2_q;
        pd_d        = pd_q;
        old_pd_d    = old_pd_q;
        imm_d       = imm_q;
        alu_op_d    = alu_op_q;
        ctrl_d      = ctrl_q;
        ovf_d       = ovf_q;

        if (accept) begin
            // Sources read the mapping before this instruction's own dest update.
            ps1_d       = rat_q[rs1];
            ps2_d       = rat_q[rs2];
            pd_d        = alloc ? free_q[head_q] : '0;
            old_pd_d    = alloc ? rat_q[rd] : '0;
            imm_d       = imm;
            alu_op_d    = alu_op;
            ctrl_d      = {alu_src, mem_to_reg, reg_write, mem_read, mem_write};
            out_valid_d = 1'b1;
            if (alloc) begin
                rat_d[rd] = free_q[head_q];
                head_d    = wrap_inc(head_q);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (push) begin
            free_d[tail_q] = retire_pd;
            tail_d         = wrap_inc(tail_q);
        end
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end

        case ({alloc, push})
            2'b10:   count_d = count_q - 1'b1;
            2'b01:   count_d = count_q + 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rat_q[i] <= PREG_W'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                free_q[i] <= PREG_W'(32 + i);
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= FL_FULL;
            out_valid_q <= 1'b0;
            ps1_q       <= '0;
            ps2_q       <= '0;
            pd_q        <= '0;
            old_pd_q    <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
            ctrl_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            rat_q       <= rat_d;
            free_q      <= free_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            ps1_q       <= ps1_d;
            ps2_q       <= ps2_d;
            pd_q        <= pd_d;
            old_pd_q    <= old_pd_d;
            imm_q       <= imm_d;
            alu_op_q    <= alu_op_d;
            ctrl_q      <= ctrl_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign ps1            = ps1_q;
    assign ps2            = ps2_q;
    assign pd             = pd_q;
    assign old_pd         = old_pd_q;
    assign out_imm        = imm_q;
    assign out_alu_op     = alu_op_q;
    assign out_alu_src    = ctrl_q[4];
    assign out_mem_to_reg = ctrl_q[3];
    assign out_reg_write  = ctrl_q[2];
    assign out_mem_read   = ctrl_q[1];
    assign out_mem_write  = ctrl_q[0];
    assign fl_overflow    = ovf_q;

endmodule

// File: tb/tb_rename_stage.sv
// tb/tb_rename_stage.sv - scoreboard bench for rename_stage against a queue-based rename model
module tb_rename_stage;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic [31:0] imm = '0;
    logic [2:0]  alu_op = '0;
    logic        alu_src = 1'b0, mem_to_reg = 1'b0, reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [5:0]  ps1, ps2, pd, old_pd;
    logic [31:0] out_imm;
    logic [2:0]  out_alu_op;
    logic        out_alu_src, out_mem_to_reg, out_reg_write, out_mem_read, out_mem_write;
    logic        retire_valid = 1'b0;
    logic [5:0]  retire_pd = '0;
    logic        fl_overflow;

    rename_stage #(.PHYS_REGS(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .ps1(ps1), .ps2(ps2), .pd(pd), .old_pd(old_pd),
        .out_imm(out_imm), .out_alu_op(out_alu_op), .out_alu_src(out_alu_src),
        .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .retire_valid(retire_valid), .retire_pd(retire_pd), .fl_overflow(fl_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  ps1;
        logic [5:0]  ps2;
        logic [5:0]  pd;
        logic [5:0]  old_pd;
        logic [31:0] imm;
        logic [2:0]  alu_op;
        logic [4:0]  ctrl;
    } pkt_t;

    int   rat[32];
    int   fl[$];
    bit   m_valid, m_ovf;
    pkt_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rat[i] = i;
        fl.delete();
        for (int i = 0; i < DEPTH; i++) fl.push_back(32 + i);
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        sb.delete();
    endtask

    // Reference model: advances on each clock edge from the inputs the driver presented.
    always @(posedge clk) begin
        int   start;
        bit   rdy;
        pkt_t p;
        if (!reset) begin
            start = fl.size();
            rdy   = (!m_valid || out_ready) && (start != 0);
            if (in_valid && rdy) begin
                p.ps1 = 6'(rat[rs1]);
                p.ps2 = 6'(rat[rs2]);
                if (reg_write && rd != 0) begin
                    p.pd     = 6'(fl.pop_front());
                    p.old_pd = 6'(rat[rd]);
                    rat[rd]  = int'(p.pd);
                end else begin
                    p.pd     = '0;
                    p.old_pd = '0;
                end
                p.imm    = imm;
                p.alu_op = alu_op;
                p.ctrl   = {alu_src, mem_to_reg, reg_write, mem_read, mem_write};
                sb.push_back(p);
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (retire_valid && retire_pd != 0) begin
                if (start == DEPTH) m_ovf = 1'b1;
                else fl.push_back(int'(retire_pd));
            end
        end
    end

    // Monitor: the presented packet must match the scoreboard head every cycle it is held.
    always @(negedge clk) begin
        pkt_t got;
        #2;
        if (!reset) begin
            check("in_ready", 64'(in_ready), 64'((!m_valid || out_ready) && fl.size() != 0));
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("fl_overflow", 64'(fl_overflow), 64'(m_ovf));
            if (out_valid) begin
                got = {ps1, ps2, pd, old_pd, out_imm, out_alu_op,
                       out_alu_src, out_mem_to_reg, out_reg_write, out_mem_read, out_mem_write};
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pkt_unexpected: got %0h expected no packet at %0t", got, $time);
                end else begin
                    check("pkt", got, sb[0]);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #3;
    endtask

    task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic rw, input logic [31:0] im);
        @(negedge clk);
        in_valid  = 1'b1;
        rs1       = a;
        rs2       = b;
        rd        = d;
        reg_write = rw;
        imm       = im;
        alu_op    = 3'($urandom);
        {alu_src, mem_to_reg, mem_read, mem_write} = 4'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic retire(input logic [5:0] p);
        @(negedge clk);
        retire_valid = 1'b1;
        retire_pd    = p;
        @(posedge clk);
        #1;
        retire_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #3;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_pd", 64'(pd), 64'd0);

        issue(5'd1, 5'd2, 5'd3, 1'b1, 32'h11);
        check("add_ps1", 64'(ps1), 64'd1);
        check("add_ps2", 64'(ps2), 64'd2);
        check("add_pd", 64'(pd), 64'd32);
        check("add_old", 64'(old_pd), 64'd3);
        issue(5'd3, 5'd3, 5'd4, 1'b1, 32'h22);
        check("sub_ps1", 64'(ps1), 64'd32);
        check("sub_ps2", 64'(ps2), 64'd32);
        check("sub_pd", 64'(pd), 64'd33);
        check("sub_old", 64'(old_pd), 64'd4);
        issue(5'd0, 5'd0, 5'd0, 1'b1, 32'd5);
        check("x0_pd", 64'(pd), 64'd0);
        check("x0_old", 64'(old_pd), 64'd0);
        issue(5'd1, 5'd2, 5'd7, 1'b0, 32'h8);
        check("sw_pd", 64'(pd), 64'd0);
        issue(5'd5, 5'd5, 5'd5, 1'b1, 32'h9);
        check("head_kept_pd", 64'(pd), 64'd34);

        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            in_valid     = ($urandom % 10) < 6;
            rs1          = 5'($urandom);
            rs2          = 5'($urandom);
            rd           = 5'($urandom);
            reg_write    = ($urandom % 10) < 7;
            imm          = $urandom;
            alu_op       = 3'($urandom);
            {alu_src, mem_to_reg, mem_read, mem_write} = 4'($urandom);
            out_ready    = ($urandom % 4) != 0;
            retire_valid = ($urandom % 2) != 0;
            retire_pd    = 6'($urandom);
        end
        @(negedge clk);
        in_valid     = 1'b0;
        retire_valid = 1'b0;
        out_ready    = 1'b1;
        repeat (3) @(negedge clk);

        do_reset();
        for (int i = 0; i < 32; i++) issue(5'(i % 31 + 1), 5'd0, 5'(i % 31 + 1), 1'b1, 32'(i));
        check("drain_pd", 64'(pd), 64'd63);
        check("empty_stall", 64'(in_ready), 64'd0);
        retire(6'd3);
        check("refill_ready", 64'(in_ready), 64'd1);
        issue(5'd1, 5'd1, 5'd9, 1'b1, 32'h33);
        check("reuse_pd", 64'(pd), 64'd3);

        retire(6'd20);
        retire(6'd21);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rs1       = 5'd9;
        rs2       = 5'd9;
        rd        = 5'd10;
        reg_write = 1'b1;
        imm       = 32'h44;
        @(posedge clk);
        #1;
        check("hold_first_pd", 64'(pd), 64'd20);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("hold_ready", 64'(in_ready), 64'd0);
            check("hold_pd", 64'(pd), 64'd20);
            check("hold_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        issue(5'd10, 5'd10, 5'd11, 1'b1, 32'h55);
        check("after_hold_ps1", 64'(ps1), 64'd20);
        check("after_hold_pd", 64'(pd), 64'd21);

        do_reset();
        for (int i = 0; i < 4; i++) retire(6'(10 + i));
        check("ovf_set", 64'(fl_overflow), 64'd1);
        issue(5'd3, 5'd4, 5'd3, 1'b1, 32'h66);
        @(negedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_pd", 64'(pd), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(5'd3, 5'd7, 5'd3, 1'b1, 32'h77);
        check("post_rst_ps1", 64'(ps1), 64'd3);
        check("post_rst_ps2", 64'(ps2), 64'd7);
        check("post_rst_pd", 64'(pd), 64'd32);
        check("post_rst_old", 64'(old_pd), 64'd3);
        check("post_rst_ovf", 64'(fl_overflow), 64'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
